seg_scan_decoder: RTL and testbench
===================================

# seg_scan_decoder

Receive-side counterpart of the multiplexed seven-segment display driver. Samples the 8-bit segment bus and the 6-bit digit-select bus, and waits for each digit dwell to settle. Decodes each segment pattern back to BCD and assembles a complete six-digit frame (HH MM SS or YY MM DD, as displayed). Used as an on-board self-check and as a bridge to a remote display, sitting on the Digitron_Out/DigitronCS_Out nets beside the display controller.

## Interface
- SEG_ACTIVE_LOW, 1, segment bus polarity (1: lit segment = 0)
- CS_ACTIVE_LOW, 1, select bus polarity (1: selected digit = 0)
- STABLE_CYCLES, 16, cycles a (select, segment) pair must be unchanged before capture; 2..255
- TIMEOUT_CYCLES, 5_000_000, cycles without any capture before a scan is declared lost (100 ms at 50 MHz)
- clk_50MHz  input  1  sole clock
- rst  input  1  reset, asynchronous and active-high
- seg_in  input  8  segment bus; bit0=a … bit6=g, bit7=dp
- cs_in  input  6  digit select; bit5 = leftmost digit, bit0 = rightmost
- frame_bcd  output  24  assembled frame; [23:20] leftmost digit … [3:0] rightmost
- frame_dp  output  6  decimal-point state per digit, same order as cs_in
- frame_valid  output  1  one-cycle pulse when frame_bcd/frame_dp update
- frame_bad  output  1  qualifies frame_valid: frame contains an undecodable digit
- err_cs  output  1  one-cycle pulse: settled select bus had more than one digit active
- err_timeout  output  1  one-cycle pulse: TIMEOUT_CYCLES elapsed with no capture

## Operation
- Inputs are double-flopped, then normalised to active-high using the polarity parameters. The error checks and the decoder see only the normalised values.
- State machine WAIT → SETTLE → HELD:
  - WAIT: the synchronised pair is latched as the reference. Go to SETTLE, with the stability counter at 1.
  - SETTLE: if the pair differs from the reference, re-latch it and restart the count at 1. When the count reaches STABLE_CYCLES, evaluate the pair and go to HELD.
  - HELD: stay until the pair differs from the reference, then go to WAIT.
- Evaluation of a settled pair:
  - Select all-inactive (blanking): ignored; no capture.
  - Select with more than one bit active: pulse err_cs; no capture.
  - Select one-hot: decode segments[6:0] to BCD; store the digit, its dp and its bad flag in slot i; set mask bit i.
- Decode table, gfedcba, active-high:
  - 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66
  - 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F
  - 7 with segment f (0x27) and 9 without segment d (0x67) are also accepted.
  - Any other pattern stores 4'hF with the bad flag set.
- Frame completion: when the mask reaches 6'b111111, a single register update copies the slot registers to frame_bcd/frame_dp. frame_bad = OR of the bad flags. frame_valid pulses and the mask clears.
- Recapturing a digit already in the mask overwrites its slot. The mask is unchanged.
- Timeout: a counter clears on every capture and increments otherwise. At TIMEOUT_CYCLES it pulses err_timeout, clears the mask and restarts from 0. frame_* outputs hold.

## Timing
- Reset values:
  - frame_bcd = 24'h000000, frame_dp = 0
  - frame_valid = frame_bad = err_cs = err_timeout = 0
  - mask = 0, state = WAIT, all counters = 0
- Latency: input edge to synchroniser output is 2 cycles. Settle takes STABLE_CYCLES further cycles. Capture registers 1 cycle later.
- frame_valid asserts the cycle after the sixth capture; outputs are stable from that edge.
- A glitch shorter than STABLE_CYCLES restarts the count and is never captured.
- Capture and timeout in the same cycle: capture wins and the timeout counter clears.
- Reset asserted mid-frame clears immediately and asynchronously. The first frame_valid after release needs six fresh captures.
- Pulse outputs are exactly one cycle wide; they never stretch.

## Structure
- Shared package `clock_pkg`:
  - seven-segment pattern constants SEG_0..SEG_9
  - NUM_DIGITS = 6
  - state encoding for the WAIT/SETTLE/HELD states
- Sub-module `seg7_to_bcd`: combinational pattern → {bad, bcd[3:0]} using the package constants. Shared with future display test logic.
- Top-level file holds the synchroniser, FSM, mask, slot registers and timeout counter.

## Test plan
- Scan "235959" active-low, 50 000-cycle dwell per digit, bit5 first → frame_valid once per scan, frame_bcd=24'h235959, frame_bad=0, frame_dp=0.
- 5-cycle glitch on seg_in inside a dwell, STABLE_CYCLES=16 → no err, frame unchanged at 24'h235959.
- Digit at bit2 shows 0x49 → frame_bcd[11:8]=4'hF, frame_bad=1 with frame_valid.
- cs_in normalised 6'b000011, held 20 cycles → err_cs pulses once; mask unchanged; no frame_valid.
- Scan stops after 3 digits for TIMEOUT_CYCLES → err_timeout pulses, mask cleared; next full scan yields one frame_valid.
- rst asserted during 4th digit of a scan → all outputs 0 asynchronously; frame_valid only after 6 new captures.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared constants for the clock display path: seven-segment patterns
// (gfedcba, active-high), digit count and the scan-decoder FSM states.
package clock_pkg;

  localparam int unsigned NUM_DIGITS = 6;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  // Alternate glyphs some drivers use: 7 with segment f, 9 without segment d
  localparam logic [6:0] SEG_7_ALT = 7'h27;
  localparam logic [6:0] SEG_9_ALT = 7'h67;

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_SETTLE,
    ST_HELD
  } scan_state_t;

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational seven-segment (gfedcba, active-high) to BCD decoder.
// Unknown patterns return 4'hF with o_bad set.
module seg7_to_bcd
  import clock_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic       o_bad,
  output logic [3:0] o_bcd
);

  always_comb begin
    o_bad = 1'b0;
    o_bcd = 4'hF;
    case (i_seg)
      SEG_0:            o_bcd = 4'd0;
      SEG_1:            o_bcd = 4'd1;
      SEG_2:            o_bcd = 4'd2;
      SEG_3:            o_bcd = 4'd3;
      SEG_4:            o_bcd = 4'd4;
      SEG_5:            o_bcd = 4'd5;
      SEG_6:            o_bcd = 4'd6;
      SEG_7, SEG_7_ALT: o_bcd = 4'd7;
      SEG_8:            o_bcd = 4'd8;
      SEG_9, SEG_9_ALT: o_bcd = 4'd9;
      default:          o_bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Receive side of the multiplexed seven-segment bus: waits for each digit
// dwell to settle, decodes it, and assembles six-digit frames.
module seg_scan_decoder
  import clock_pkg::*;
#(
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          CS_ACTIVE_LOW  = 1'b1,
  parameter int unsigned STABLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
  input  logic        clk_50MHz,
  input  logic        rst,
  input  logic [7:0]  seg_in,
  input  logic [5:0]  cs_in,
  output logic [23:0] frame_bcd,
  output logic [5:0]  frame_dp,
  output logic        frame_valid,
  output logic        frame_bad,
  output logic        err_cs,
  output logic        err_timeout
);

  localparam int unsigned TO_W       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]  SEG_INV    = {8{SEG_ACTIVE_LOW}};
  localparam logic [5:0]  CS_INV     = {6{CS_ACTIVE_LOW}};
  localparam logic [7:0]  STABLE_END = 8'(STABLE_CYCLES);
  localparam logic [TO_W-1:0] TO_END = TO_W'(TIMEOUT_CYCLES - 1);

  logic [7:0]      r_seg_s1, r_seg_s2, r_ref_seg;
  logic [5:0]      r_cs_s1, r_cs_s2, r_ref_cs;
  logic [7:0]      r_stable_cnt;
  scan_state_t     r_state;
  logic [5:0]      r_mask;
  logic [3:0]      r_slot_bcd [NUM_DIGITS];
  logic [5:0]      r_slot_dp, r_slot_bad;
  logic [TO_W-1:0] r_to_cnt;

  logic [7:0] w_seg;
  logic [5:0] w_cs;
  logic       w_same, w_eval, w_multi, w_capture, w_mask_full, w_to_hit;
  logic       w_dec_bad;
  logic [3:0] w_dec_bcd;

  // Synchroniser resets to the idle bus level so reset never looks like a multi-select
  assign w_seg       = r_seg_s2 ^ SEG_INV;
  assign w_cs        = r_cs_s2 ^ CS_INV;
  assign w_same      = (w_seg == r_ref_seg) && (w_cs == r_ref_cs);
  assign w_eval      = (r_state == ST_SETTLE) && w_same && (r_stable_cnt == STABLE_END);
  assign w_multi     = (r_ref_cs & (r_ref_cs - 6'd1)) != 6'd0;
  assign w_capture   = w_eval && (r_ref_cs != 6'd0) && !w_multi;
  assign w_mask_full = (r_mask == 6'h3F);
  assign w_to_hit    = !w_capture && (r_to_cnt == TO_END);

  seg7_to_bcd u_dec (
    .i_seg (r_ref_seg[6:0]),
    .o_bad (w_dec_bad),
    .o_bcd (w_dec_bcd)
  );

  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      r_seg_s1     <= SEG_INV;
      r_seg_s2     <= SEG_INV;
      r_cs_s1      <= CS_INV;
      r_cs_s2      <= CS_INV;
      r_ref_seg    <= '0;
      r_ref_cs     <= '0;
      r_stable_cnt <= '0;
      r_state      <= ST_WAIT;
    end else begin
      r_seg_s1 <= seg_in;
      r_seg_s2 <= r_seg_s1;
      r_cs_s1  <= cs_in;
      r_cs_s2  <= r_cs_s1;
      case (r_state)
        ST_WAIT: begin
          r_ref_seg    <= w_seg;
          r_ref_cs     <= w_cs;
          r_stable_cnt <= 8'd1;
          r_state      <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (!w_same) begin
            r_ref_seg    <= w_seg;
            r_ref_cs     <= w_cs;
            r_stable_cnt <= 8'd1;
          end else if (r_stable_cnt == STABLE_END) begin
            r_state <= ST_HELD;
          end else begin
            r_stable_cnt <= r_stable_cnt + 8'd1;
          end
        end
        ST_HELD: if (!w_same) r_state <= ST_WAIT;
        default: r_state <= ST_WAIT;
      endcase
    end
  end

  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      r_mask      <= '0;
      r_slot_dp   <= '0;
      r_slot_bad  <= '0;
      r_to_cnt    <= '0;
      frame_bcd   <= '0;
      frame_dp    <= '0;
      frame_valid <= 1'b0;
      frame_bad   <= 1'b0;
      err_cs      <= 1'b0;
      err_timeout <= 1'b0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) r_slot_bcd[i] <= '0;
    end else begin
      frame_valid <= 1'b0;
      err_cs      <= w_eval && w_multi;
      err_timeout <= w_to_hit;

      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (w_capture && r_ref_cs[i]) begin
          r_slot_bcd[i] <= w_dec_bcd;
          r_slot_dp[i]  <= r_ref_seg[7];
          r_slot_bad[i] <= w_dec_bad;
        end
      end

      // Completion reads the slots one cycle after the sixth capture wrote them
      if (w_mask_full) begin
        for (int unsigned i = 0; i < NUM_DIGITS; i++) frame_bcd[i*4 +: 4] <= r_slot_bcd[i];
        frame_dp    <= r_slot_dp;
        frame_bad   <= |r_slot_bad;
        frame_valid <= 1'b1;
      end

      if (w_capture)
        r_mask <= (w_mask_full ? 6'd0 : r_mask) | r_ref_cs;
      else if (w_mask_full || w_to_hit)
        r_mask <= '0;

      if (w_capture || w_to_hit)
        r_to_cnt <= '0;
      else
        r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Randomised bench for seg_scan_decoder: drives digit dwells on active-low
// buses and compares frames/error pulses against a dwell-level model.
module tb_seg_scan_decoder;

  localparam int unsigned STABLE  = 16;
  localparam int unsigned TIMEOUT = 2000;
  localparam logic [7:0] PAT [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                      8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  logic        clk_50MHz = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  seg_in = 8'hFF;
  logic [5:0]  cs_in = 6'h3F;
  logic [23:0] frame_bcd;
  logic [5:0]  frame_dp;
  logic        frame_valid, frame_bad, err_cs, err_timeout;

  seg_scan_decoder #(
    .SEG_ACTIVE_LOW (1'b1),
    .CS_ACTIVE_LOW  (1'b1),
    .STABLE_CYCLES  (STABLE),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk_50MHz   (clk_50MHz),
    .rst         (rst),
    .seg_in      (seg_in),
    .cs_in       (cs_in),
    .frame_bcd   (frame_bcd),
    .frame_dp    (frame_dp),
    .frame_valid (frame_valid),
    .frame_bad   (frame_bad),
    .err_cs      (err_cs),
    .err_timeout (err_timeout)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  typedef struct {
    logic [23:0] bcd;
    logic [5:0]  dp;
    logic        bad;
  } frame_t;

  frame_t      exp_q[$];
  int unsigned n_vec = 0, n_bad = 0;
  int unsigned exp_cs = 0, act_cs = 0, exp_to = 0, act_to = 0;
  logic [23:0] m_bcd = '0;
  logic [5:0]  m_dp = '0, m_bad = '0, m_mask = '0;
  logic [5:0]  last_cs = '0;
  logic [7:0]  last_seg = '0;
  logic        prev_fv = 1'b0, prev_cs = 1'b0, prev_to = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] ref_decode(input logic [6:0] p);
    for (int d = 0; d < 10; d++)
      if (p == PAT[d][6:0]) return {1'b0, 4'(d)};
    if (p == 7'h27) return 5'd7;
    if (p == 7'h67) return 5'd9;
    return 5'h1F;
  endfunction

  // A settled dwell: blanking does nothing, multi-select is an error, one-hot fills a slot
  function automatic void model_capture(input logic [5:0] cs, input logic [7:0] seg);
    logic [4:0] d;
    if (cs == 6'd0) return;
    if ($countones(cs) > 1) begin
      exp_cs++;
      return;
    end
    d = ref_decode(seg[6:0]);
    for (int i = 0; i < 6; i++) begin
      if (cs[i]) begin
        m_bcd[i*4 +: 4] = d[3:0];
        m_bad[i] = d[4];
        m_dp[i] = seg[7];
        m_mask[i] = 1'b1;
      end
    end
    if (m_mask == 6'h3F) begin
      exp_q.push_back('{bcd: m_bcd, dp: m_dp, bad: |m_bad});
      m_mask = '0;
    end
  endfunction

  // Drive an active-high (cs, seg) pair for len cycles; settles when counted
  task automatic apply(input logic [5:0] cs, input logic [7:0] seg,
                       input int unsigned len, input bit settles);
    cs_in = ~cs;
    seg_in = ~seg;
    last_cs = cs;
    last_seg = seg;
    if (settles) model_capture(cs, seg);
    repeat (len) @(posedge clk_50MHz);
    #1;
  endtask

  task automatic scan(input logic [23:0] digits, input int unsigned dwell);
    logic [3:0] d;
    for (int k = 5; k >= 0; k--) begin
      d = digits[k*4 +: 4];
      apply(6'(1 << k), PAT[d], dwell, 1'b1);
    end
  endtask

  always @(negedge clk_50MHz) begin
    if (rst) begin
      prev_fv <= 1'b0;
      prev_cs <= 1'b0;
      prev_to <= 1'b0;
    end else begin
      if (frame_valid) begin
        check("frame_valid_width", 32'(prev_fv), 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 32'd1, 32'd0);
        end else begin
          frame_t e;
          e = exp_q.pop_front();
          check("frame_bcd", 32'(frame_bcd), 32'(e.bcd));
          check("frame_dp", 32'(frame_dp), 32'(e.dp));
          check("frame_bad", 32'(frame_bad), 32'(e.bad));
        end
      end
      if (err_cs) begin
        check("err_cs_width", 32'(prev_cs), 32'd0);
        act_cs++;
      end
      if (err_timeout) begin
        check("err_timeout_width", 32'(prev_to), 32'd0);
        act_to++;
      end
      prev_fv <= frame_valid;
      prev_cs <= err_cs;
      prev_to <= err_timeout;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] p, g;
    logic [5:0] c;
    int unsigned r;

    repeat (3) @(posedge clk_50MHz);
    #1;
    check("rst_frame_bcd", 32'(frame_bcd), 32'd0);
    check("rst_frame_dp", 32'(frame_dp), 32'd0);
    check("rst_pulses", 32'({frame_valid, frame_bad, err_cs, err_timeout}), 32'd0);
    rst = 1'b0;
    repeat (5) @(posedge clk_50MHz);
    #1;

    scan(24'h235959, 40);
    scan(24'h235959, 40);
    check("scan_frames_pending", exp_q.size(), 32'd0);

    // Short glitch inside the bit-3 dwell must not be captured
    apply(6'b100000, PAT[2], 40, 1'b1);
    apply(6'b010000, PAT[3], 40, 1'b1);
    apply(6'b001000, PAT[5], 30, 1'b1);
    apply(6'b001000, PAT[5] ^ 8'h10, 5, 1'b0);
    apply(6'b001000, PAT[5], 30, 1'b1);
    apply(6'b000100, PAT[9], 40, 1'b1);
    apply(6'b000010, PAT[5], 40, 1'b1);
    apply(6'b000001, PAT[9], 40, 1'b1);
    check("glitch_frames_pending", exp_q.size(), 32'd0);
    check("glitch_no_err", act_cs, exp_cs);

    apply(6'b100000, PAT[1], 40, 1'b1);
    apply(6'b010000, PAT[2], 40, 1'b1);
    apply(6'b001000, PAT[3], 40, 1'b1);
    apply(6'b000100, 8'h49, 40, 1'b1);
    apply(6'b000010, PAT[4] | 8'h80, 40, 1'b1);
    apply(6'b000001, PAT[6], 40, 1'b1);
    check("bad_frames_pending", exp_q.size(), 32'd0);

    apply(6'b000011, PAT[1], 40, 1'b1);
    check("err_cs_count", act_cs, exp_cs);
    scan(24'h012345, 40);
    check("after_cs_frames_pending", exp_q.size(), 32'd0);

    apply(6'b100000, PAT[7], 40, 1'b1);
    apply(6'b010000, PAT[8], 40, 1'b1);
    apply(6'b001000, PAT[9], 40, 1'b1);
    apply(6'b000000, 8'h00, TIMEOUT * 3 / 2, 1'b0);
    exp_to++;
    m_mask = '0;
    check("err_timeout_count", act_to, exp_to);
    scan(24'h654321, 40);
    check("timeout_frames_pending", exp_q.size(), 32'd0);

    scan(24'h112233, 40);
    apply(6'b100000, PAT[4], 40, 1'b1);
    apply(6'b010000, PAT[5], 40, 1'b1);
    apply(6'b001000, PAT[6], 40, 1'b1);
    apply(6'b000100, PAT[7], 10, 1'b0);
    #3 rst = 1'b1;
    #1;
    check("mid_rst_frame_bcd", 32'(frame_bcd), 32'd0);
    check("mid_rst_frame_dp", 32'(frame_dp), 32'd0);
    check("mid_rst_pulses", 32'({frame_valid, frame_bad, err_cs, err_timeout}), 32'd0);
    cs_in = 6'h3F;
    seg_in = 8'hFF;
    last_cs = '0;
    last_seg = '0;
    m_mask = '0;
    repeat (4) @(posedge clk_50MHz);
    #1 rst = 1'b0;
    apply(6'b000010, PAT[8], 40, 1'b1);
    apply(6'b000001, PAT[0], 40, 1'b1);
    check("post_rst_no_frame", exp_q.size(), 32'd0);
    scan(24'h200109, 40);

    for (int n = 0; n < 120; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        c = 6'd0;
      end else if (r == 1) begin
        c = 6'($urandom);
        while ($countones(c) < 2) c = 6'($urandom);
      end else begin
        c = 6'(1 << $urandom_range(0, 5));
      end
      if ($urandom_range(0, 4) == 0) p = {1'b0, 7'($urandom)};
      else p = PAT[$urandom_range(0, 9)];
      p[7] = 1'($urandom);
      if (c == last_cs && p == last_seg) p[7] = ~p[7];
      if ($urandom_range(0, 5) == 0) begin
        g = p ^ {1'b0, 7'($urandom_range(1, 127))};
        apply(c, p, 30, 1'b1);
        apply(c, g, $urandom_range(1, STABLE - 4), 1'b0);
        apply(c, p, 30, 1'b1);
      end else begin
        apply(c, p, $urandom_range(30, 60), 1'b1);
      end
    end

    repeat (50) @(posedge clk_50MHz);
    #1;
    check("final_frames_pending", exp_q.size(), 32'd0);
    check("final_err_cs", act_cs, exp_cs);
    check("final_err_timeout", act_to, exp_to);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
